// File: rtl/img_stream_if.sv
// ============================================================================
//  Module   : img_stream_if
//  Purpose  : Control inputs and vsync/hsync/valid/data pixel stream of the
//             test-image generator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface img_stream_if;
  logic       start;
  logic       continuous;
  logic [1:0] pattern_sel;
  logic [7:0] const_val;
  logic       post_img_vsync;
  logic       post_img_hsync;
  logic       post_img_valid;
  logic [7:0] post_img_data;
  logic       busy;
  logic       frame_done;

  modport master (
    input  start, continuous, pattern_sel, const_val,
    output post_img_vsync, post_img_hsync, post_img_valid, post_img_data,
    output busy, frame_done
  );

  modport slave (
    output start, continuous, pattern_sel, const_val,
    input  post_img_vsync, post_img_hsync, post_img_valid, post_img_data,
    input  busy, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/img_stream_gen.sv
// ============================================================================
//  Module   : img_stream_gen
//  Purpose  : Frame-timed test-pattern source for the 3x3 window/filter chain.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module img_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 160,
  parameter int V_PRE    = 10,
  parameter int V_POST   = 10
) (
  input  logic          clk,
  input  logic          rst,
  img_stream_if.master  bus
);

  localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] H_BLK_LAST = 12'(H_BLANK - 1);
  localparam logic [11:0] V_PRE_LAST = 12'(V_PRE - 1);
  localparam logic [11:0] V_PST_LAST = 12'(V_POST - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_V_PRE      = 3'd1,
    S_LINE_ACT   = 3'd2,
    S_LINE_BLANK = 3'd3,
    S_V_POST     = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] cnt;
  logic [11:0] x;
  logic [11:0] y;
  logic [1:0]  pat;
  logic [7:0]  cval;
  // Set for the single cycle after a frame ends: it drives frame_done and
  // forms the one-cycle vsync gap ahead of a continuous relaunch.
  logic        end_flag;

  logic        launch;
  logic        frame_end;
  logic [7:0]  pix;
  logic        vsync_nxt;
  logic        hsync_nxt;
  logic [7:0]  data_nxt;
  logic        busy_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !end_flag) begin
          state_nxt = S_V_PRE;
          launch    = 1'b1;
        end
      end
      S_V_PRE: begin
        if (!end_flag && cnt == V_PRE_LAST) begin
          state_nxt = S_LINE_ACT;
        end
      end
      S_LINE_ACT: begin
        if (x == H_ACT_LAST) begin
          state_nxt = S_LINE_BLANK;
        end
      end
      S_LINE_BLANK: begin
        if (cnt == H_BLK_LAST) begin
          state_nxt = (y == V_ACT_LAST) ? S_V_POST : S_LINE_ACT;
        end
      end
      S_V_POST: begin
        if (cnt == V_PST_LAST) begin
          frame_end = 1'b1;
          if (bus.continuous) begin
            state_nxt = S_V_PRE;
            launch    = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    case (pat)
      2'd0:    pix = x[7:0];
      2'd1:    pix = y[7:0];
      2'd2:    pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      default: pix = cval;
    endcase

    vsync_nxt = (state != S_IDLE) && !end_flag;
    hsync_nxt = (state == S_LINE_ACT);
    data_nxt  = (state == S_LINE_ACT) ? pix : 8'h00;
    busy_nxt  = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 12'd0;
      x        <= 12'd0;
      y        <= 12'd0;
      pat      <= 2'd0;
      cval     <= 8'h00;
      end_flag <= 1'b0;
    end else begin
      end_flag <= frame_end;
      if (launch) begin
        cnt  <= 12'd0;
        x    <= 12'd0;
        y    <= 12'd0;
        pat  <= bus.pattern_sel;
        cval <= bus.const_val;
      end else begin
        if (state_nxt != state) begin
          cnt <= 12'd0;
        end else if (state != S_IDLE && !(state == S_V_PRE && end_flag)) begin
          cnt <= cnt + 12'd1;
        end
        if (state == S_LINE_ACT) begin
          x <= (x == H_ACT_LAST) ? 12'd0 : x + 12'd1;
        end
        if (state == S_LINE_BLANK && state_nxt == S_LINE_ACT) begin
          y <= y + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.post_img_vsync <= 1'b0;
      bus.post_img_hsync <= 1'b0;
      bus.post_img_valid <= 1'b0;
      bus.post_img_data  <= 8'h00;
      bus.busy           <= 1'b0;
      bus.frame_done     <= 1'b0;
    end else begin
      bus.post_img_vsync <= vsync_nxt;
      bus.post_img_hsync <= hsync_nxt;
      bus.post_img_valid <= hsync_nxt;
      bus.post_img_data  <= data_nxt;
      bus.busy           <= busy_nxt;
      bus.frame_done     <= end_flag;
    end
  end

endmodule

`default_nettype wire
